// File: rtl/bus_mailbox_pkg.sv
// Register map and bit positions shared by the CPU/host mailbox and its bench.
package bus_mailbox_pkg;

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_CLEAR  = 2'd3
   } reg_sel_e;

   localparam int unsigned ST_RX_NOT_EMPTY  = 0;
   localparam int unsigned ST_TX_NOT_FULL   = 1;
   localparam int unsigned ST_RX_UNDERFLOW  = 2;
   localparam int unsigned ST_TX_OVERFLOW   = 3;
   localparam int unsigned ST_TX_EMPTY      = 4;
   localparam int unsigned ST_IRQ_PENDING   = 7;

   localparam int unsigned CTRL_RX_IE       = 0;
   localparam int unsigned CTRL_TX_EMPTY_IE = 1;

   function automatic logic [7:0] pack_status(input logic rx_not_empty,
                                              input logic tx_not_full,
                                              input logic rx_underflow,
                                              input logic tx_overflow,
                                              input logic tx_empty,
                                              input logic irq_pending);
      logic [7:0] s;
      s                  = '0;
      s[ST_RX_NOT_EMPTY] = rx_not_empty;
      s[ST_TX_NOT_FULL]  = tx_not_full;
      s[ST_RX_UNDERFLOW] = rx_underflow;
      s[ST_TX_OVERFLOW]  = tx_overflow;
      s[ST_TX_EMPTY]     = tx_empty;
      s[ST_IRQ_PENDING]  = irq_pending;
      return s;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; push while full and pop while empty are ignored.
module sync_fifo #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH_BITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [WIDTH-1:0]      din,
   input  logic                  pop,
   output logic [WIDTH-1:0]      dout,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_BITS:0]   count
);
   localparam int unsigned DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [DEPTH_BITS-1:0] r_wr_ptr;
   logic [DEPTH_BITS-1:0] r_rd_ptr;
   logic [DEPTH_BITS:0]   r_count;
   logic                  w_push;
   logic                  w_pop;

   assign full   = (r_count == FULL_COUNT);
   assign empty  = (r_count == '0);
   assign count  = r_count;
   assign dout   = r_mem[r_rd_ptr];
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (w_push && !reset) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/bus_mailbox.sv
// CPU-bus mailbox: TX FIFO toward the host, RX FIFO from the host, status/ctrl/irq.
module bus_mailbox
   import bus_mailbox_pkg::*;
#(
   parameter int unsigned DEPTH_BITS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clken,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] rs,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irq_n,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready
);
   logic                w_access;
   logic                w_wr;
   logic                w_rd;
   logic                w_tx_push;
   logic                w_rx_pop;
   logic                w_tx_full;
   logic                w_tx_empty;
   logic                w_rx_full;
   logic                w_rx_empty;
   logic [7:0]          w_rx_head;
   logic [DEPTH_BITS:0] w_tx_count;
   logic [DEPTH_BITS:0] w_rx_count;
   logic                w_irq;
   logic [7:0]          w_rd_data;

   logic [7:0] r_dout;
   logic [1:0] r_ctrl;
   logic       r_rx_underflow;
   logic       r_tx_overflow;
   logic       r_irq_n;

   assign w_access  = clken && cs;
   assign w_wr      = w_access && we;
   assign w_rd      = w_access && !we;
   assign w_tx_push = w_wr && (reg_sel_e'(rs) == REG_DATA);
   assign w_rx_pop  = w_rd && (reg_sel_e'(rs) == REG_DATA);

   assign tx_valid  = !w_tx_empty;
   assign rx_ready  = !w_rx_full && !reset;
   assign dout      = r_dout;
   assign irq_n     = r_irq_n;

   assign w_irq = (r_ctrl[CTRL_RX_IE] && !w_rx_empty) ||
                  (r_ctrl[CTRL_TX_EMPTY_IE] && w_tx_empty);

   sync_fifo #(.WIDTH(8), .DEPTH_BITS(DEPTH_BITS)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_tx_push),
      .din   (din),
      .pop   (tx_ready),
      .dout  (tx_data),
      .full  (w_tx_full),
      .empty (w_tx_empty),
      .count (w_tx_count)
   );

   sync_fifo #(.WIDTH(8), .DEPTH_BITS(DEPTH_BITS)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_valid),
      .din   (rx_data),
      .pop   (w_rx_pop),
      .dout  (w_rx_head),
      .full  (w_rx_full),
      .empty (w_rx_empty),
      .count (w_rx_count)
   );

   always_comb begin
      w_rd_data = '0;
      case (reg_sel_e'(rs))
         REG_DATA:   w_rd_data = w_rx_empty ? 8'h00 : w_rx_head;
         REG_STATUS: w_rd_data = pack_status(!w_rx_empty, !w_tx_full, r_rx_underflow,
                                             r_tx_overflow, w_tx_empty, w_irq);
         REG_CTRL:   w_rd_data = {6'b0, r_ctrl};
         default:    w_rd_data = '0;
      endcase
   end

   // Sticky flags: set and clear can never coincide since each cycle carries one access.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dout         <= '0;
         r_ctrl         <= '0;
         r_rx_underflow <= 1'b0;
         r_tx_overflow  <= 1'b0;
         r_irq_n        <= 1'b1;
      end else begin
         r_irq_n <= !w_irq;
         if (w_rd) begin
            r_dout <= w_rd_data;
         end
         if (w_wr && (reg_sel_e'(rs) == REG_CTRL)) begin
            r_ctrl <= din[1:0];
         end
         if (w_tx_push && w_tx_full) begin
            r_tx_overflow <= 1'b1;
         end else if (w_wr && (reg_sel_e'(rs) == REG_CLEAR) && din[ST_TX_OVERFLOW]) begin
            r_tx_overflow <= 1'b0;
         end
         if (w_rx_pop && w_rx_empty) begin
            r_rx_underflow <= 1'b1;
         end else if (w_wr && (reg_sel_e'(rs) == REG_CLEAR) && din[ST_RX_UNDERFLOW]) begin
            r_rx_underflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bus_mailbox.sv
// Directed-vector bench for bus_mailbox (DEPTH_BITS=4) with hand-computed expectations.
module tb_bus_mailbox;

   logic       clk = 1'b0;
   logic       reset;
   logic       clken;
   logic       cs;
   logic       we;
   logic [1:0] rs;
   logic [7:0] din;
   logic [7:0] dout;
   logic       irq_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;
   logic [7:0]  rd;

   bus_mailbox #(.DEPTH_BITS(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .clken    (clken),
      .cs       (cs),
      .we       (we),
      .rs       (rs),
      .din      (din),
      .dout     (dout),
      .irq_n    (irq_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %02h expected %02h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [1:0] r, input logic [7:0] d);
      clken = 1'b1; cs = 1'b1; we = 1'b1; rs = r; din = d;
      step();
      clken = 1'b0; cs = 1'b0; we = 1'b0;
   endtask

   task automatic cpu_read(input logic [1:0] r, output logic [7:0] d);
      clken = 1'b1; cs = 1'b1; we = 1'b0; rs = r;
      step();
      clken = 1'b0; cs = 1'b0;
      d = dout;
   endtask

   task automatic host_push(input logic [7:0] d);
      rx_valid = 1'b1; rx_data = d;
      step();
      rx_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; clken = 1'b0; cs = 1'b0; we = 1'b0; rs = 2'd0; din = 8'h00;
      tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
      step();
      step();
      check_eq("rst_dout", dout, 8'h00);
      check_eq("rst_irq_n", {7'b0, irq_n}, 8'h01);
      check_eq("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
      check_eq("rst_rx_ready", {7'b0, rx_ready}, 8'h00);
      reset = 1'b0;
      #1;
      check_eq("post_rst_rx_ready", {7'b0, rx_ready}, 8'h01);

      // clken without cs must not push
      clken = 1'b1; cs = 1'b0; we = 1'b1; rs = 2'd0; din = 8'hEE;
      step();
      clken = 1'b0; we = 1'b0;
      check_eq("no_cs_tx_valid", {7'b0, tx_valid}, 8'h00);

      // three bytes then drain
      cpu_write(2'd0, 8'h11);
      cpu_write(2'd0, 8'h22);
      cpu_write(2'd0, 8'h33);
      check_eq("tx_valid_held", {7'b0, tx_valid}, 8'h01);
      check_eq("tx_head0", tx_data, 8'h11);
      tx_ready = 1'b1;
      step();
      check_eq("tx_head1", tx_data, 8'h22);
      step();
      check_eq("tx_head2", tx_data, 8'h33);
      step();
      check_eq("tx_drained", {7'b0, tx_valid}, 8'h00);
      tx_ready = 1'b0;

      // overflow: 17 writes into a 16-deep FIFO
      for (int i = 0; i < 17; i++) cpu_write(2'd0, 8'h40 + 8'(i));
      cpu_read(2'd1, rd);
      check_eq("ovf_status", rd, 8'h08);
      cpu_write(2'd3, 8'h08);
      cpu_read(2'd1, rd);
      check_eq("ovf_cleared", rd, 8'h00);
      tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check_eq($sformatf("ovf_drain%0d", i), tx_data, 8'h40 + 8'(i));
         step();
      end
      check_eq("ovf_17th_dropped", {7'b0, tx_valid}, 8'h00);
      tx_ready = 1'b0;

      // RX fill to full
      for (int i = 0; i < 16; i++) begin
         check_eq($sformatf("rx_ready_fill%0d", i), {7'b0, rx_ready}, 8'h01);
         rx_valid = 1'b1; rx_data = 8'h80 + 8'(i);
         step();
      end
      rx_valid = 1'b0;
      check_eq("rx_full_ready", {7'b0, rx_ready}, 8'h00);
      cpu_read(2'd1, rd);
      check_eq("rx_full_status", rd, 8'h13);
      cpu_read(2'd0, rd);
      check_eq("rx_first", rd, 8'h80);
      check_eq("rx_ready_back", {7'b0, rx_ready}, 8'h01);
      for (int i = 1; i < 16; i++) begin
         cpu_read(2'd0, rd);
         check_eq($sformatf("rx_drain%0d", i), rd, 8'h80 + 8'(i));
      end

      // underflow, then underflow coinciding with a host push
      cpu_read(2'd0, rd);
      check_eq("unf_dout", rd, 8'h00);
      cpu_read(2'd1, rd);
      check_eq("unf_status", rd, 8'h16);
      rx_valid = 1'b1; rx_data = 8'h5A;
      cpu_read(2'd0, rd);
      rx_valid = 1'b0;
      check_eq("unf_push_dout", rd, 8'h00);
      cpu_read(2'd1, rd);
      check_eq("unf_push_status", rd, 8'h17);
      cpu_read(2'd0, rd);
      check_eq("unf_push_kept", rd, 8'h5A);
      cpu_read(2'd1, rd);
      check_eq("unf_push_empty", rd, 8'h16);
      cpu_write(2'd3, 8'h04);
      cpu_read(2'd1, rd);
      check_eq("unf_cleared", rd, 8'h12);

      // rx interrupt
      cpu_write(2'd2, 8'h01);
      cpu_read(2'd2, rd);
      check_eq("ctrl_readback", rd, 8'h01);
      host_push(8'hA5);
      check_eq("irq_lag", {7'b0, irq_n}, 8'h01);
      step();
      check_eq("irq_asserted", {7'b0, irq_n}, 8'h00);
      cpu_read(2'd0, rd);
      check_eq("irq_data", rd, 8'hA5);
      step();
      check_eq("irq_released", {7'b0, irq_n}, 8'h01);

      // tx-empty interrupt
      cpu_write(2'd2, 8'h02);
      step();
      check_eq("txe_irq", {7'b0, irq_n}, 8'h00);
      cpu_read(2'd1, rd);
      check_eq("txe_status", rd, 8'h92);

      // reset with 5 TX bytes, a pending RX irq and a write in flight
      cpu_write(2'd2, 8'h01);
      host_push(8'h33);
      for (int i = 0; i < 5; i++) cpu_write(2'd0, 8'hC0 + 8'(i));
      check_eq("pre_rst_irq", {7'b0, irq_n}, 8'h00);
      reset = 1'b1;
      clken = 1'b1; cs = 1'b1; we = 1'b1; rs = 2'd0; din = 8'h99;
      step();
      clken = 1'b0; cs = 1'b0; we = 1'b0;
      check_eq("rst2_tx_valid", {7'b0, tx_valid}, 8'h00);
      check_eq("rst2_dout", dout, 8'h00);
      check_eq("rst2_irq_n", {7'b0, irq_n}, 8'h01);
      check_eq("rst2_rx_ready", {7'b0, rx_ready}, 8'h00);
      reset = 1'b0;
      #1;
      check_eq("rst2_rx_ready_after", {7'b0, rx_ready}, 8'h01);
      cpu_read(2'd1, rd);
      check_eq("rst2_status", rd, 8'h12);
      cpu_read(2'd2, rd);
      check_eq("rst2_ctrl", rd, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
